// File: rtl/fp_comp_arb.sv
// Round-robin arbiter/sequencer sharing one registered fp comparator among N requesters.
// Operands are held for the comparator's full latency, then flags are returned tagged with the requester ID.
module fp_comp_arb #(
  parameter int N   = 4,
  parameter int IDW = 2,
  parameter int LAT = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic [32*N-1:0] req_a,
  input  logic [32*N-1:0] req_b,
  output logic [N-1:0]    gnt,
  output logic            busy,
  output logic            rsp_valid,
  output logic [IDW-1:0]  rsp_id,
  output logic            rsp_less,
  output logic            rsp_eq,
  output logic            rsp_great,
  output logic            rsp_inv,
  output logic [31:0]     cmp_in1,
  output logic [31:0]     cmp_in2,
  output logic            cmp_act,
  input  logic            cmp_less,
  input  logic            cmp_eq,
  input  logic            cmp_great,
  input  logic            cmp_done,
  input  logic            cmp_inv,
  output logic [1:0]      state_dbg
);

  localparam int CW = (LAT < 1) ? 1 : $clog2(LAT + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, CAPT = 2'd2} state_t;

  // Handshake: req is a level; a requester holds req and operands stable until
  // it sees its one-cycle gnt pulse; rsp_valid is a one-cycle pulse with no backpressure.

  state_t          state, state_nxt;
  logic [IDW-1:0]  last, last_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [N-1:0]    gnt_nxt;
  logic            busy_nxt, act_nxt, rsp_valid_nxt;
  logic [IDW-1:0]  rsp_id_nxt;
  logic [3:0]      flags, flags_nxt;
  logic [31:0]     in1_nxt, in2_nxt;

  logic            win_hit;
  logic [IDW-1:0]  win;
  logic [31:0]     win_a, win_b;

  assign state_dbg = state;
  assign {rsp_less, rsp_eq, rsp_great, rsp_inv} = flags;

  // Search begins one past the last winner so every requester is reached within N-1 grants.
  always_comb begin : win_search
    int idx;
    win_hit = 1'b0;
    win     = '0;
    win_a   = '0;
    win_b   = '0;
    idx     = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last) + k) % N;
      if (!win_hit && req[idx]) begin
        win_hit = 1'b1;
        win     = IDW'(idx);
        win_a   = req_a[idx*32 +: 32];
        win_b   = req_b[idx*32 +: 32];
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    last_nxt      = last;
    cnt_nxt       = cnt;
    gnt_nxt       = '0;
    rsp_valid_nxt = 1'b0;
    busy_nxt      = busy;
    act_nxt       = cmp_act;
    in1_nxt       = cmp_in1;
    in2_nxt       = cmp_in2;
    rsp_id_nxt    = rsp_id;
    flags_nxt     = flags;
    case (state)
      IDLE: begin
        if (win_hit) begin
          in1_nxt      = win_a;
          in2_nxt      = win_b;
          gnt_nxt[win] = 1'b1;
          last_nxt     = win;
          cnt_nxt      = CW'(LAT);
          busy_nxt     = 1'b1;
          act_nxt      = 1'b1;
          state_nxt    = WAIT;
        end
      end
      WAIT: begin
        if (cnt != '0) cnt_nxt = cnt - 1'b1;
        else           state_nxt = CAPT;
      end
      CAPT: begin
        // A comparator that never reported done yields an invalid result, not stale flags.
        flags_nxt     = cmp_done ? {cmp_less, cmp_eq, cmp_great, cmp_inv} : 4'b0001;
        rsp_id_nxt    = last;
        rsp_valid_nxt = 1'b1;
        busy_nxt      = 1'b0;
        act_nxt       = 1'b0;
        state_nxt     = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      last      <= IDW'(N - 1);
      cnt       <= '0;
      gnt       <= '0;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      flags     <= '0;
      cmp_in1   <= '0;
      cmp_in2   <= '0;
      cmp_act   <= 1'b0;
    end else begin
      state     <= state_nxt;
      last      <= last_nxt;
      cnt       <= cnt_nxt;
      gnt       <= gnt_nxt;
      busy      <= busy_nxt;
      rsp_valid <= rsp_valid_nxt;
      rsp_id    <= rsp_id_nxt;
      flags     <= flags_nxt;
      cmp_in1   <= in1_nxt;
      cmp_in2   <= in2_nxt;
      cmp_act   <= act_nxt;
    end
  end

endmodule

// File: tb/tb_fp_comp_arb.sv
// Directed bench for fp_comp_arb with a small behavioural comparator of latency LAT.
module tb_fp_comp_arb;
  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int LAT = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N-1:0]    req = '0;
  logic [32*N-1:0] req_a = '0;
  logic [32*N-1:0] req_b = '0;
  logic [N-1:0]    gnt;
  logic            busy, rsp_valid;
  logic [IDW-1:0]  rsp_id;
  logic            rsp_less, rsp_eq, rsp_great, rsp_inv;
  logic [31:0]     cmp_in1, cmp_in2;
  logic            cmp_act;
  logic            cmp_less, cmp_eq, cmp_great, cmp_done, cmp_inv;
  logic [1:0]      state_dbg;

  int vectors = 0;
  int miscompares = 0;
  logic force_nodone = 1'b0;

  fp_comp_arb #(.N(N), .IDW(IDW), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .req(req), .req_a(req_a), .req_b(req_b),
    .gnt(gnt), .busy(busy), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_less(rsp_less), .rsp_eq(rsp_eq), .rsp_great(rsp_great), .rsp_inv(rsp_inv),
    .cmp_in1(cmp_in1), .cmp_in2(cmp_in2), .cmp_act(cmp_act),
    .cmp_less(cmp_less), .cmp_eq(cmp_eq), .cmp_great(cmp_great),
    .cmp_done(cmp_done), .cmp_inv(cmp_inv), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // Comparator model: {less, eq, great, inv}; inf/NaN go invalid, opposite-signed zeros are eq+inv.
  function automatic logic [31:0] fkey(input logic [31:0] x);
    return x[31] ? ~x : (x | 32'h8000_0000);
  endfunction

  function automatic logic [3:0] fp_model(input logic [31:0] a, input logic [31:0] b);
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) return 4'b0001;
    if (a[30:0] == 31'd0 && b[30:0] == 31'd0) return (a[31] != b[31]) ? 4'b0101 : 4'b0100;
    if (fkey(a) < fkey(b)) return 4'b1000;
    if (fkey(a) == fkey(b)) return 4'b0100;
    return 4'b0010;
  endfunction

  logic [3:0] p1 = '0, p2 = '0;
  logic       d1 = 1'b0, d2 = 1'b0;
  always @(posedge clk) begin
    p1 <= fp_model(cmp_in1, cmp_in2);
    p2 <= p1;
    d1 <= cmp_act;
    d2 <= d1;
  end
  assign {cmp_less, cmp_eq, cmp_great, cmp_inv} = p2;
  assign cmp_done = d2 & ~force_nodone;

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[i*32 +: 32] = a;
    req_b[i*32 +: 32] = b;
  endtask

  task automatic do_reset;
    rst = 1'b0;
    req = '0;
    tick();
    rst = 1'b1;
  endtask

  // Issues one request from requester i and waits (bounded) for its response.
  task automatic run_single(input int i, input logic [31:0] a, input logic [31:0] b,
                            output logic [N-1:0] g, output int lat,
                            output logic [3:0] fl, output logic [IDW-1:0] id);
    set_ops(i, a, b);
    req = '0;
    req[i] = 1'b1;
    tick();
    g = gnt;
    req = '0;
    lat = -1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (rsp_valid) begin
        lat = k;
        break;
      end
    end
    fl = {rsp_less, rsp_eq, rsp_great, rsp_inv};
    id = rsp_id;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    req = '0;
    tick();
    vectors++;
    if ({gnt, busy, rsp_valid, cmp_act} !== '0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got gnt=%b busy=%b rv=%b act=%b expected all 0", gnt, busy, rsp_valid, cmp_act);
    end
    vectors++;
    if ({rsp_id, rsp_less, rsp_eq, rsp_great, rsp_inv} !== '0) begin
      miscompares++;
      $display("FAIL reset_rsp: got id=%0d flags=%b expected 0", rsp_id, {rsp_less, rsp_eq, rsp_great, rsp_inv});
    end
    vectors++;
    if ({cmp_in1, cmp_in2} !== 64'd0 || state_dbg !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_ops: got in1=%h in2=%h st=%0d expected 0", cmp_in1, cmp_in2, state_dbg);
    end
    rst = 1'b1;
    tick();
    vectors++;
    if (gnt !== '0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_hold: got gnt=%b busy=%b expected 0000/0", gnt, busy);
    end
  endtask

  task automatic test_single;
    set_ops(0, 32'h3F80_0000, 32'h4000_0000);
    req = 4'b0001;
    tick();
    vectors++;
    if (gnt !== 4'b0001 || {busy, cmp_act} !== 2'b11) begin
      miscompares++;
      $display("FAIL single_gnt: got gnt=%b busy=%b act=%b expected 0001/1/1", gnt, busy, cmp_act);
    end
    vectors++;
    if (cmp_in1 !== 32'h3F80_0000 || cmp_in2 !== 32'h4000_0000) begin
      miscompares++;
      $display("FAIL single_ops: got %h %h expected 3f800000 40000000", cmp_in1, cmp_in2);
    end
    req = '0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      vectors++;
      if (rsp_valid !== (k == 4) || gnt !== '0) begin
        miscompares++;
        $display("FAIL single_timing G+%0d: got rv=%b gnt=%b expected rv=%b gnt=0000", k, rsp_valid, gnt, k == 4);
      end
    end
    vectors++;
    if ({rsp_id, rsp_less, rsp_eq, rsp_great, rsp_inv, busy, cmp_act} !== {2'd0, 4'b1000, 2'b00}) begin
      miscompares++;
      $display("FAIL single_rsp: got id=%0d flags=%b busy=%b act=%b expected 0/1000/0/0",
               rsp_id, {rsp_less, rsp_eq, rsp_great, rsp_inv}, busy, cmp_act);
    end
    tick();
    vectors++;
    if (rsp_valid !== 1'b0 || rsp_less !== 1'b1) begin
      miscompares++;
      $display("FAIL single_pulse: got rv=%b less=%b expected 0/1 (flags held)", rsp_valid, rsp_less);
    end
  endtask

  task automatic test_round_robin;
    do_reset();
    for (int i = 0; i < N; i++) set_ops(i, 32'h3F80_0000, 32'h3F80_0000);
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      tick();
      vectors++;
      if (gnt !== 4'(1 << (g % 4))) begin
        miscompares++;
        $display("FAIL rr_gnt #%0d: got %b expected %b", g, gnt, 4'(1 << (g % 4)));
      end
      if (g == 4) req = '0;
      for (int k = 1; k <= 4; k++) tick();
      vectors++;
      if ({rsp_valid, rsp_id, rsp_less, rsp_eq, rsp_great, rsp_inv} !== {1'b1, 2'(g % 4), 4'b0100}) begin
        miscompares++;
        $display("FAIL rr_rsp #%0d: got rv=%b id=%0d flags=%b expected 1/%0d/0100", g, rsp_valid, rsp_id,
                 {rsp_less, rsp_eq, rsp_great, rsp_inv}, g % 4);
      end
    end
    tick();
  endtask

  task automatic test_flags;
    logic [N-1:0] g;
    int lat;
    logic [3:0] fl;
    logic [IDW-1:0] id;
    run_single(1, 32'h7FA0_0000, 32'h3F80_0000, g, lat, fl, id);
    vectors++;
    if (g !== 4'b0010 || lat !== 4 || fl !== 4'b0001 || id !== 2'd1) begin
      miscompares++;
      $display("FAIL snan: got gnt=%b lat=%0d flags=%b id=%0d expected 0010/4/0001/1", g, lat, fl, id);
    end
    run_single(3, 32'h0000_0000, 32'h8000_0000, g, lat, fl, id);
    vectors++;
    if (g !== 4'b1000 || lat !== 4 || fl !== 4'b0101 || id !== 2'd3) begin
      miscompares++;
      $display("FAIL zeros: got gnt=%b lat=%0d flags=%b id=%0d expected 1000/4/0101/3", g, lat, fl, id);
    end
    run_single(2, 32'h7F80_0000, 32'h3F80_0000, g, lat, fl, id);
    vectors++;
    if (g !== 4'b0100 || fl !== 4'b0001 || id !== 2'd2) begin
      miscompares++;
      $display("FAIL inf: got gnt=%b flags=%b id=%0d expected 0100/0001/2", g, fl, id);
    end
    run_single(0, 32'hC000_0000, 32'h3F80_0000, g, lat, fl, id);
    vectors++;
    if (fl !== 4'b1000 || id !== 2'd0) begin
      miscompares++;
      $display("FAIL neg_less: got flags=%b id=%0d expected 1000/0", fl, id);
    end
    run_single(1, 32'h4040_0000, 32'h4000_0000, g, lat, fl, id);
    vectors++;
    if (fl !== 4'b0010 || id !== 2'd1) begin
      miscompares++;
      $display("FAIL great: got flags=%b id=%0d expected 0010/1", fl, id);
    end
    force_nodone = 1'b1;
    run_single(0, 32'h3F80_0000, 32'h4000_0000, g, lat, fl, id);
    force_nodone = 1'b0;
    vectors++;
    if (fl !== 4'b0001 || lat !== 4) begin
      miscompares++;
      $display("FAIL no_done: got flags=%b lat=%0d expected 0001/4", fl, lat);
    end
  endtask

  task automatic test_withdraw;
    tick();
    set_ops(2, 32'h4000_0000, 32'h3F80_0000);
    set_ops(1, 32'h3F80_0000, 32'h3F80_0000);
    req = 4'b0100;
    tick();
    vectors++;
    if (gnt !== 4'b0100) begin
      miscompares++;
      $display("FAIL wd_gnt: got %b expected 0100", gnt);
    end
    req = '0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k == 1) req = 4'b0010;
      vectors++;
      if (gnt !== '0) begin
        miscompares++;
        $display("FAIL wd_ignore G+%0d: got gnt=%b expected 0000", k, gnt);
      end
    end
    vectors++;
    if ({rsp_valid, rsp_id, rsp_less, rsp_eq, rsp_great, rsp_inv} !== {1'b1, 2'd2, 4'b0010}) begin
      miscompares++;
      $display("FAIL wd_rsp: got rv=%b id=%0d flags=%b expected 1/2/0010", rsp_valid, rsp_id,
               {rsp_less, rsp_eq, rsp_great, rsp_inv});
    end
    tick();
    vectors++;
    if (gnt !== 4'b0010) begin
      miscompares++;
      $display("FAIL wd_next: got gnt=%b at G+5 expected 0010", gnt);
    end
    req = '0;
    for (int k = 1; k <= 5; k++) tick();
  endtask

  task automatic test_reset_mid;
    logic seen;
    set_ops(3, 32'h3F80_0000, 32'h4000_0000);
    req = 4'b1000;
    tick();
    vectors++;
    if (gnt !== 4'b1000) begin
      miscompares++;
      $display("FAIL rm_gnt: got %b expected 1000", gnt);
    end
    req = '0;
    tick();
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    vectors++;
    if ({gnt, busy, rsp_valid, rsp_id, rsp_less, rsp_eq, rsp_great, rsp_inv, cmp_act, cmp_in1, cmp_in2, state_dbg} !== '0) begin
      miscompares++;
      $display("FAIL rm_clear: got gnt=%b busy=%b act=%b in1=%h st=%0d flags=%b expected all 0",
               gnt, busy, cmp_act, cmp_in1, state_dbg, {rsp_less, rsp_eq, rsp_great, rsp_inv});
    end
    seen = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      tick();
      seen |= rsp_valid;
    end
    set_ops(0, 32'h4000_0000, 32'h4000_0000);
    req = 4'b1001;
    rst = 1'b1;
    tick();
    vectors++;
    if (gnt !== 4'b0001) begin
      miscompares++;
      $display("FAIL rm_first: got gnt=%b expected 0001", gnt);
    end
    req = '0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      seen |= rsp_valid;
    end
    vectors++;
    if (seen !== 1'b0) begin
      miscompares++;
      $display("FAIL rm_no_rsp: got rsp_valid=%b expected 0", seen);
    end
    tick();
    vectors++;
    if ({rsp_valid, rsp_id, rsp_less, rsp_eq, rsp_great, rsp_inv} !== {1'b1, 2'd0, 4'b0100}) begin
      miscompares++;
      $display("FAIL rm_rsp: got rv=%b id=%0d flags=%b expected 1/0/0100", rsp_valid, rsp_id,
               {rsp_less, rsp_eq, rsp_great, rsp_inv});
    end
    tick();
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_round_robin();
    test_flags();
    test_withdraw();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fp_comp_arb.md
# fp_comp_arb

Round-robin arbiter and sequencer that shares one registered floating-point comparator (`fp_comp`, instanced alongside it at the FPU top) between N requesters. It grants one request at a time and drives and holds the comparator operands for the comparator's full internal latency, including its slower exception path. It then captures `less/eq/great/inv` and returns them tagged with the requester ID. It sits between the FPU issue logic and the comparator.

## Interface
- `N`, 4, number of requesters (2..8)
- `IDW`, 2, requester ID width, equals ceil(log2(N))
- `LAT`, 2, comparator latency in clock edges from operand change to settled exception-path outputs

- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `req`  in  N  per-requester compare request, level
- `req_a`  in  32*N  operand A of requester i at bits [32i+31:32i]
- `req_b`  in  32*N  operand B, same packing
- `gnt`  out  N  one-hot, one-cycle pulse: operands of requester i were latched
- `busy`  out  1  compare in flight
- `rsp_valid`  out  1  one-cycle pulse, response fields valid
- `rsp_id`  out  IDW  requester the response belongs to
- `rsp_less`, `rsp_eq`, `rsp_great`, `rsp_inv`  out  1 each  captured comparator flags
- `cmp_in1`, `cmp_in2`  out  32 each  comparator operands (registered)
- `cmp_act`  out  1  comparator activate, high while a compare is in flight
- `cmp_less`, `cmp_eq`, `cmp_great`, `cmp_done`, `cmp_inv`  in  1 each  comparator registered outputs

## Operation
- FSM states: IDLE, WAIT, CAPT.
- IDLE, `req`==0: hold; all outputs stay at their last values except the pulses, which are 0.
- IDLE, `req`!=0: select the winner by round-robin. Search starts at `last+1` mod N; first set bit wins.
  - Latch `req_a`/`req_b` of the winner into `cmp_in1`/`cmp_in2`.
  - Set `gnt[win]`=1 for one cycle, `last`=win, `cnt`=LAT, `busy`=1, `cmp_act`=1. Go to WAIT.
- WAIT: `cmp_in1`/`cmp_in2` held constant. If `cnt`!=0, decrement `cnt`. If `cnt`==0, go to CAPT.
- CAPT:
  - Register `rsp_less/eq/great/inv` from `cmp_*`. If `cmp_done`==0, force `rsp_inv`=1 and the other flags 0.
  - `rsp_id`=last, `rsp_valid`=1 for one cycle, `busy`=0, `cmp_act`=0. Go to IDLE.
- Requester protocol:
  - Keep `req` and operands stable until `gnt` is seen.
  - Drop `req` the cycle after `gnt`, or keep it high to request again.
  - A request withdrawn before grant is simply not served.
  - Deasserting `req` after grant does not cancel the compare; the response is still delivered.
- Flag semantics are the comparator's and pass through unmodified: NaN, ±0 equality, and infinity handling all come from the comparator.
- Response fields hold their value until the next CAPT. Only `rsp_valid` pulses.

## Timing
- Reset (async, `rst`=0) forces:
  - state=IDLE, `last`=N-1 (requester 0 has first priority), `cnt`=0.
  - All outputs 0: `gnt`, `busy`, `rsp_*`, `cmp_in1`, `cmp_in2`, `cmp_act`.
- Reset mid-compare: the in-flight compare is lost and no `rsp_valid` is issued. After `rst` rises, the first rising edge behaves as IDLE.
- G = edge at which IDLE sees `req` and grants. `gnt` is high in cycle G..G+1.
- Comparator outputs for the new operands are settled (normal and exception path) after edge G+LAT.
- WAIT spans edges G+1..G+LAT+1, so CAPT is entered at G+LAT+1.
- Response registers load at edge G+LAT+2; `rsp_valid` is high in cycle G+LAT+2..G+LAT+3.
- Next grant is possible at edge G+LAT+3. Throughput is one compare per LAT+3 cycles (5 with defaults).
- `busy` is high from edge G to edge G+LAT+2.
- Simultaneous requests: exactly one `gnt` bit is set per grant. No requester waits more than N-1 grants while continuously requesting.
- `req` changes during WAIT/CAPT are ignored until IDLE.

## Test plan
- Single request, LAT=2: `req`=0001, A=0x3F800000 (1.0), B=0x40000000 (2.0) at edge 0.
  - `gnt`=0001 in cycle 0–1.
  - `rsp_valid` in cycle 4–5 with `rsp_id`=0, less=1, eq=0, great=0, inv=0.
- Round-robin: `req`=1111 held constant, all A=B=0x3F800000.
  - Grants go to 0,1,2,3,0 every 5 cycles.
  - Each response has eq=1 and the matching `rsp_id`.
- Exception path: A = codebase signalling-NaN encoding, B=0x3F800000.
  - Response has inv=1, less=eq=great=0.
  - Confirms capture after the exception path settles, not stale normal-path flags.
- Zero and infinity: A=0x00000000, B=0x80000000 → eq=1, inv=1. A=0x7F800000, B=0x3F800000 → inv=1, other flags 0.
- Withdrawal: `req`=0100 dropped one cycle after `gnt` → response still delivered with `rsp_id`=2. Then `req`=0010 raised during WAIT → granted only at edge G+LAT+3.
- Reset mid-compare: assert `rst`=0 at G+2.
  - All outputs 0 immediately and no `rsp_valid` afterward.
  - After release with `req`=1001, requester 0 is granted first.
